// File: rtl/tpu_pkg.sv
// Shared TPU types: byte and weight-row addressing plus the burst streaming engine's
// length and state types.
package tpu_pkg;

  localparam int BYTE_WIDTH   = 8;
  localparam int MATRIX_WIDTH = 14;
  localparam int TILE_WIDTH   = 32768;

  typedef logic [BYTE_WIDTH-1:0]                byte_type;
  typedef logic [$clog2(TILE_WIDTH)-1:0]        weight_addr_type;
  typedef logic [$clog2(MATRIX_WIDTH+1)-1:0]    burst_len_type;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } stream_state_type;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head entry whenever
// the FIFO is not empty. Used as the stream skid buffer.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage is not reset; the occupancy count alone decides what is valid,
  // which keeps the array mappable onto plain registers/RAM without a reset net.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_stream_buffer.sv
// Dual-port weight RAM: port 0 is a byte-masked host read/write port with a gated read
// pipeline; port 1 is a burst engine streaming consecutive rows over valid/ready.
module weight_stream_buffer #(
  parameter int MATRIX_WIDTH      = tpu_pkg::MATRIX_WIDTH,
  parameter int TILE_WIDTH        = tpu_pkg::TILE_WIDTH,
  parameter int READ_LATENCY      = 3,
  parameter int STREAM_FIFO_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        enable,
  input  logic [$clog2(TILE_WIDTH)-1:0]               addr0,
  input  logic                                        en0,
  input  logic                                        write_en0,
  input  logic [MATRIX_WIDTH-1:0]                     byte_en0,
  input  logic [MATRIX_WIDTH*tpu_pkg::BYTE_WIDTH-1:0] write_port0,
  output logic [MATRIX_WIDTH*tpu_pkg::BYTE_WIDTH-1:0] read_port0,
  input  logic                                        burst_start,
  input  logic [$clog2(TILE_WIDTH)-1:0]               burst_addr,
  input  logic [$clog2(MATRIX_WIDTH+1)-1:0]           burst_len,
  output logic                                        burst_busy,
  output logic                                        burst_done,
  output logic                                        stream_valid,
  input  logic                                        stream_ready,
  output logic [MATRIX_WIDTH*tpu_pkg::BYTE_WIDTH-1:0] stream_data,
  output logic                                        stream_last
);

  import tpu_pkg::*;

  localparam int ROW_W  = MATRIX_WIDTH * BYTE_WIDTH;
  localparam int ADDR_W = $clog2(TILE_WIDTH);
  localparam int LEN_W  = $clog2(MATRIX_WIDTH+1);
  localparam int CNT_W  = $clog2(STREAM_FIFO_DEPTH+1);

  logic [ROW_W-1:0] mem [TILE_WIDTH];
  logic [ROW_W-1:0] pipe_q [READ_LATENCY];

  // Port-1 read register; rd1_valid_q marks the single in-flight read.
  logic [ROW_W-1:0] rd1_data_q;
  logic             rd1_valid_q;

  stream_state_type  state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  accepted_q;
  logic              burst_done_q;

  logic              issue;
  logic              handshake;
  logic              last_handshake;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ROW_W-1:0]  fifo_data;

  // Non-blocking writes give read-first behaviour on both ports for a same-row collision.
  always_ff @(posedge clk) begin
    if (en0 && write_en0) begin
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
        if (byte_en0[i])
          mem[addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_port0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (issue) rd1_data_q <= mem[addr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else if (enable) begin
      if (en0) pipe_q[0] <= mem[addr0];
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign read_port0 = pipe_q[READ_LATENCY-1];

  sync_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (STREAM_FIFO_DEPTH)
  ) u_stream_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd1_valid_q && !fifo_full),
    .wr_data (rd1_data_q),
    .rd_en   (handshake),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign stream_valid   = !fifo_empty;
  assign stream_data    = fifo_empty ? '0 : fifo_data;
  assign stream_last    = stream_valid && (accepted_q == len_q - LEN_W'(1));
  assign handshake      = stream_valid && stream_ready;
  assign last_handshake = handshake && stream_last;
  assign burst_busy     = (state_q != IDLE);
  assign burst_done     = burst_done_q;

  // Only issue when the read already in flight still has a guaranteed FIFO slot.
  assign issue = (state_q == ISSUE) &&
                 ((fifo_count + CNT_W'(rd1_valid_q)) < CNT_W'(STREAM_FIFO_DEPTH));

  // NOTE: next state is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_start && burst_len != '0) state_d = ISSUE;
      ISSUE:   if (issue && issued_q == len_q - LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (last_handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      rd1_valid_q  <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd1_valid_q  <= issue;
      burst_done_q <= (state_q == DRAIN) && last_handshake;
      if (state_q == IDLE && state_d == ISSUE) begin
        addr_q     <= burst_addr;
        len_q      <= burst_len;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + LEN_W'(1);
        end
        if (handshake) accepted_q <= accepted_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Directed bench for weight_stream_buffer: masked writes, read latency and freeze,
// burst timing, back-pressure, wrap, ignored requests, collision and reset.
module tb_weight_stream_buffer;

  localparam int MW    = 14;
  localparam int TW    = 32768;
  localparam int ROW_W = MW * 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [14:0]       addr0;
  logic              en0;
  logic              write_en0;
  logic [MW-1:0]     byte_en0;
  logic [ROW_W-1:0]  write_port0;
  logic [ROW_W-1:0]  read_port0;
  logic              burst_start;
  logic [14:0]       burst_addr;
  logic [3:0]        burst_len;
  logic              burst_busy;
  logic              burst_done;
  logic              stream_valid;
  logic              stream_ready;
  logic [ROW_W-1:0]  stream_data;
  logic              stream_last;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  weight_stream_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .addr0        (addr0),
    .en0          (en0),
    .write_en0    (write_en0),
    .byte_en0     (byte_en0),
    .write_port0  (write_port0),
    .read_port0   (read_port0),
    .burst_start  (burst_start),
    .burst_addr   (burst_addr),
    .burst_len    (burst_len),
    .burst_busy   (burst_busy),
    .burst_done   (burst_done),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_data  (stream_data),
    .stream_last  (stream_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_pat(input int r);
    logic [ROW_W-1:0] v;
    logic [15:0]      rr;
    rr = 16'(r);
    v[7:0]  = rr[7:0];
    v[15:8] = rr[15:8];
    for (int i = 2; i < MW; i++) v[i*8 +: 8] = rr[7:0] ^ 8'(i * 17);
    return v;
  endfunction

  // Advance one cycle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (burst_done) done_cnt++;
  endtask

  task automatic write_row(input int a, input logic [ROW_W-1:0] d, input logic [MW-1:0] be);
    en0 = 1'b1; write_en0 = 1'b1; addr0 = 15'(a); byte_en0 = be; write_port0 = d;
    tick();
    en0 = 1'b0; write_en0 = 1'b0;
  endtask

  task automatic read_row(input int a, output logic [ROW_W-1:0] d);
    en0 = 1'b1; write_en0 = 1'b0; addr0 = 15'(a);
    tick();
    en0 = 1'b0;
    tick();
    tick();
    d = read_port0;
  endtask

  task automatic start_burst(input int a, input int len);
    burst_addr = 15'(a); burst_len = 4'(len); burst_start = 1'b1; stream_ready = 1'b1;
  endtask

  // Streams with ready held high until burst_done or the cycle budget runs out.
  task automatic collect(input int base, input int len, input int max_cyc, output int beats);
    beats = 0;
    for (int c = 0; c < max_cyc && done_cnt == 0; c++) begin
      tick();
      burst_start = 1'b0; en0 = 1'b0; write_en0 = 1'b0; stream_ready = 1'b1;
      if (stream_valid) begin
        check("stream_data", stream_data, row_pat((base + beats) % TW));
        check("stream_last", ROW_W'(stream_last), ROW_W'(beats == len - 1));
        beats++;
      end
    end
  endtask

  initial begin
    logic [ROW_W-1:0] rd;
    logic [ROW_W-1:0] prev_data;
    logic             prev_stall;
    int               beats;

    rst = 1'b1; enable = 1'b1; addr0 = '0; en0 = 1'b0; write_en0 = 1'b0; byte_en0 = '0;
    write_port0 = '0; burst_start = 1'b0; burst_addr = '0; burst_len = '0; stream_ready = 1'b0;
    #1;
    check("rst_read_port0", read_port0, '0);
    check("rst_stream_data", stream_data, '0);
    check("rst_valid", ROW_W'(stream_valid), '0);
    check("rst_last", ROW_W'(stream_last), '0);
    check("rst_busy", ROW_W'(burst_busy), '0);
    check("rst_done", ROW_W'(burst_done), '0);
    tick();
    tick();
    rst = 1'b0;

    // Masked write: bytes 0-1 become 0xFF, the rest keep 0x11.
    write_row(5, {MW{8'h11}}, '1);
    write_row(5, {MW{8'hFF}}, 14'h0003);
    read_row(5, rd);
    check("masked_write", rd, 112'h1111_1111_1111_1111_1111_1111_FFFF);

    for (int r = 0; r < 14; r++) write_row(r, row_pat(r), '1);
    for (int r = 20; r < 26; r++) write_row(r, row_pat(r), '1);
    for (int r = 40; r < 43; r++) write_row(r, row_pat(r), '1);
    write_row(TW - 2, row_pat(TW - 2), '1);
    write_row(TW - 1, row_pat(TW - 1), '1);

    // Read pipeline freeze: two enable=0 cycles delay the result by two cycles.
    read_row(2, rd);
    check("read_row2", rd, row_pat(2));
    en0 = 1'b1; addr0 = 15'd9;
    tick();
    en0 = 1'b0; enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    check("freeze_hold", read_port0, row_pat(2));
    tick();
    check("freeze_release", read_port0, row_pat(9));

    // Full burst, cycle-exact timing.
    done_cnt = 0;
    start_burst(0, 14);
    check("full_busy_c0", ROW_W'(burst_busy), '0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      burst_start = 1'b0;
      check("full_valid", ROW_W'(stream_valid), ROW_W'(cyc >= 3 && cyc <= 16));
      check("full_last", ROW_W'(stream_last), ROW_W'(cyc == 16));
      check("full_busy", ROW_W'(burst_busy), ROW_W'(cyc >= 1 && cyc <= 16));
      check("full_done", ROW_W'(burst_done), ROW_W'(cyc == 17));
      if (cyc >= 3 && cyc <= 16) check("full_data", stream_data, row_pat(cyc - 3));
    end

    // Back-pressure with ready pattern 1,0,0 repeating.
    done_cnt = 0; beats = 0; prev_stall = 1'b0; prev_data = '0;
    start_burst(20, 6);
    for (int k = 1; k < 80 && done_cnt == 0; k++) begin
      tick();
      burst_start = 1'b0;
      stream_ready = (k % 3 == 0);
      if (prev_stall) begin
        check("bp_hold_valid", ROW_W'(stream_valid), ROW_W'(1'b1));
        check("bp_hold_data", stream_data, prev_data);
      end
      if (stream_valid && stream_ready) begin
        check("bp_data", stream_data, row_pat(20 + beats));
        check("bp_last", ROW_W'(stream_last), ROW_W'(beats == 5));
        beats++;
      end
      prev_stall = stream_valid && !stream_ready;
      prev_data  = stream_data;
    end
    check("bp_beats", ROW_W'(beats), ROW_W'(6));
    check("bp_done_cnt", ROW_W'(done_cnt), ROW_W'(1));

    // Address wrap across the top of the tile.
    done_cnt = 0;
    start_burst(TW - 2, 4);
    collect(TW - 2, 4, 30, beats);
    check("wrap_beats", ROW_W'(beats), ROW_W'(4));
    check("wrap_done_cnt", ROW_W'(done_cnt), ROW_W'(1));

    // Ignored requests: zero length, then a second start while busy.
    done_cnt = 0;
    start_burst(0, 0);
    tick();
    burst_start = 1'b0;
    check("zero_len_busy", ROW_W'(burst_busy), '0);
    tick();
    check("zero_len_valid", ROW_W'(stream_valid), '0);
    start_burst(0, 3);
    tick();
    check("ign_busy", ROW_W'(burst_busy), ROW_W'(1'b1));
    start_burst(100, 5);
    collect(0, 3, 30, beats);
    for (int c = 0; c < 8; c++) tick();
    check("ign_beats", ROW_W'(beats), ROW_W'(3));
    check("ign_done_cnt", ROW_W'(done_cnt), ROW_W'(1));
    check("ign_idle", ROW_W'(burst_busy), '0);

    // Collision: port-0 write to row 40 in the cycle its stream read is issued.
    done_cnt = 0;
    start_burst(40, 3);
    tick();
    burst_start = 1'b0;
    en0 = 1'b1; write_en0 = 1'b1; addr0 = 15'd40; byte_en0 = '1; write_port0 = {MW{8'hA5}};
    collect(40, 3, 30, beats);
    check("coll_beats", ROW_W'(beats), ROW_W'(3));
    read_row(40, rd);
    check("coll_new_value", rd, {MW{8'hA5}});

    // Reset mid-burst: outputs clear, no done pulse, RAM kept.
    done_cnt = 0;
    start_burst(0, 8);
    for (int c = 0; c < 4; c++) begin
      tick();
      burst_start = 1'b0;
    end
    check("mid_valid", ROW_W'(stream_valid), ROW_W'(1'b1));
    rst = 1'b1;
    #1;
    check("mid_rst_read_port0", read_port0, '0);
    check("mid_rst_data", stream_data, '0);
    check("mid_rst_valid", ROW_W'(stream_valid), '0);
    check("mid_rst_last", ROW_W'(stream_last), '0);
    check("mid_rst_busy", ROW_W'(burst_busy), '0);
    tick();
    check("mid_rst_done", ROW_W'(burst_done), '0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("mid_no_done", ROW_W'(done_cnt), '0);
    check("mid_idle_valid", ROW_W'(stream_valid), '0);
    read_row(3, rd);
    check("mid_ram_kept", rd, row_pat(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_stream_buffer.md
# weight_stream_buffer

Dual-port weight storage that adds per-byte write enables, a parametrised read pipeline and a burst streaming engine. Port 0 is a random-access host port used by the weight loader and the debug path. Port 1 is an engine that streams up to MATRIX_WIDTH consecutive weight rows into the systolic array's weight-load path over a valid/ready handshake. The engine absorbs back-pressure without dropping or duplicating beats.

## Interface
- MATRIX_WIDTH, 14: bytes per weight row; maximum burst length.
- TILE_WIDTH, 32768: rows of storage; must be a power of two.
- READ_LATENCY, 3: port-0 read latency in cycles; must be ≥1.
- STREAM_FIFO_DEPTH, 4: stream skid-buffer entries; must be ≥2.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  advances the port-0 read pipeline; 0 freezes it.
- addr0  in  weight_addr_type  port-0 row address.
- en0  in  1  port-0 access strobe.
- write_en0  in  1  port-0 write.
- byte_en0  in  MATRIX_WIDTH  per-byte write mask.
- write_port0  in  byte_type[MATRIX_WIDTH]  write row.
- read_port0  out  byte_type[MATRIX_WIDTH]  read row.
- burst_start  in  1  one-cycle burst request.
- burst_addr  in  weight_addr_type  first row of the burst.
- burst_len  in  burst_len_type  number of rows, 0..MATRIX_WIDTH.
- burst_busy  out  1  engine not IDLE.
- burst_done  out  1  one-cycle completion pulse.
- stream_valid  out  1  stream_data is valid.
- stream_ready  in  1  consumer accepts the beat.
- stream_data  out  byte_type[MATRIX_WIDTH]  streamed row.
- stream_last  out  1  final beat of the burst.

## Operation
- **Port-0 write:** when en0 and write_en0 are high, only the bytes i with byte_en0[i]=1 are updated.
- **Port-0 read:** every en0 access reads the row. The RAM read is registered and followed by READ_LATENCY-1 pipeline registers. These registers advance only when enable=1.
- **Same-cycle collision:** a port-0 write and a port-1 read to the same row return the old data (read-first). A simultaneous port-0 write and any port-1 access never corrupt the row.
- **Engine states:** IDLE, ISSUE, DRAIN.
- **IDLE → ISSUE:** on burst_start with burst_len≠0. The engine latches the address and length and clears its issued and accepted counters.
- **Ignored requests:** burst_start with burst_len=0, and burst_start while busy, are ignored silently.
- **ISSUE:** issues one RAM read per cycle while in-flight reads (0..1) plus FIFO occupancy is less than STREAM_FIFO_DEPTH.
- **Address wrap:** the address increments modulo TILE_WIDTH, so TILE_WIDTH-1 is followed by 0.
- **ISSUE → DRAIN:** after burst_len reads have been issued.
- **DRAIN → IDLE:** on the handshake (valid & ready) carrying stream_last. burst_done pulses in the following cycle.
- **Stream output:** stream_last is high only on beat burst_len. stream_data and stream_last hold stable while stream_valid=1 and stream_ready=0.
- **Stream width:** the stream path carries full rows; byte masking applies to writes only.

## Timing
- **Reset values:** read_port0=0, stream_data=0, stream_valid=0, stream_last=0, burst_busy=0, burst_done=0. Reset clears FIFO occupancy and returns the engine to IDLE.
- **Reset mid-burst:** aborts the burst without a burst_done pulse. RAM contents are preserved.
- **Port-0 latency:** en0 in cycle t gives read_port0 in cycle t+READ_LATENCY, provided enable=1 throughout.
- **Stream latency:** burst_start sampled in cycle 0 gives the first stream_valid in cycle 3. With stream_ready held at 1, one beat is delivered per cycle, the last beat is in cycle 2+burst_len, and burst_done is in cycle 3+burst_len.
- **burst_busy:** high from cycle 1 through cycle 2+burst_len.
- **Back-pressure:** there is no throughput loss after stream_ready returns to 1. There are no bubbles while the FIFO is non-empty.

## Structure
- **Package tpu_pkg:** add burst_len_type (logic [$clog2(MATRIX_WIDTH+1)-1:0]) and stream_state_type (enum IDLE/ISSUE/DRAIN). Reuse the existing BYTE_WIDTH, byte_type and weight_addr_type.
- **Sub-module sync_fifo:** parameters WIDTH and DEPTH; ports wr_en, rd_en, full, empty, count; first-word-fall-through output. It is the stream skid buffer.
- **Top level:** holds the RAM, the port-0 pipeline and the engine state machine.

## Test plan
- **Masked write:** write row 5 with all bytes 0x11, then write 0xFF with byte_en0=0x0003 → read_port0 shows bytes 0–1 = 0xFF and the rest 0x11, 3 cycles after en0.
- **Full burst:** burst_addr=0, burst_len=14, stream_ready=1 → rows 0..13 arrive in cycles 3..16, stream_last in cycle 16, burst_done in cycle 17.
- **Back-pressure:** burst_len=6, stream_ready toggling 1,0,0,1… → all 6 rows arrive in order with none lost or duplicated, and data holds while stalled.
- **Wrap:** burst_addr=TILE_WIDTH-2, burst_len=4 → rows 32766, 32767, 0, 1 are streamed.
- **Ignored requests:** burst_start during a burst, or with burst_len=0 → no effect, and burst_done pulses exactly once.
- **Reset and collision:** rst asserted mid-burst → all outputs are 0 next cycle and there is no burst_done. A port-0 write to the row being streamed in the same cycle → the stream carries the old value, and a later read shows the new value.
